// File: rtl/hpdmc_sdram_responder_pkg.sv
// rtl/hpdmc_sdram_responder_pkg.sv - command encodings, mode-register decode and sizing helpers
// Package hpdmc_resp_pkg (no ports): cmd_e {ras_n,cas_n,we_n} encodings, burst FSM states,
// mode-register reset values, CL/BL field decode and legality functions, word-index width.
package hpdmc_resp_pkg;

   typedef enum logic [2:0] {
      CMD_LMR   = 3'b000,
      CMD_REF   = 3'b001,
      CMD_PRE   = 3'b010,
      CMD_ACT   = 3'b011,
      CMD_WRITE = 3'b100,
      CMD_READ  = 3'b101,
      CMD_BST   = 3'b110,   // burst terminate: not modelled, behaves as NOP
      CMD_NOP   = 3'b111
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WBURST = 2'd1,
      ST_RBURST = 2'd2
   } burst_state_e;

   localparam logic [2:0] CL_FIELD_2    = 3'd2;
   localparam logic [2:0] CL_FIELD_3    = 3'd3;
   localparam logic       CL3_RESET     = 1'b1;    // CL=3
   localparam logic [1:0] BL_MASK_RESET = 2'b01;   // BL=4 -> 2 words

   // Word index = {ba, row, col[COL_W-1:1]}
   function automatic int idx_width(input int row_w, input int col_w);
      return 2 + row_w + col_w - 1;
   endfunction

   function automatic logic cl_legal(input logic [2:0] f);
      return (f == CL_FIELD_2) || (f == CL_FIELD_3);
   endfunction

   function automatic logic bl_legal(input logic [2:0] f);
      return (f >= 3'd1) && (f <= 3'd3);
   endfunction

   // Only CL=2 selects the short read path; every other field value falls back to CL=3.
   function automatic logic cl_decode_is3(input logic [2:0] f);
      return f != CL_FIELD_2;
   endfunction

   // Burst length expressed as (words per burst - 1), which doubles as the wrap mask.
   function automatic logic [1:0] bl_decode_mask(input logic [2:0] f);
      case (f)
         3'd1:    return 2'b00;
         3'd2:    return 2'b01;
         3'd3:    return 2'b11;
         default: return BL_MASK_RESET;
      endcase
   endfunction

endpackage

// File: rtl/hpdmc_sdram_responder_if.sv
// rtl/hpdmc_sdram_responder_if.sv - HPDMC SDR-side command/data bus between controller and responder
// master (controller): drives cs_n, ras_n, cas_n, we_n, ba[1:0], a[12:0], wdata[31:0], wmask[3:0];
//   samples rdata[31:0], rdata_valid, dq_oe, busy, err.
// slave (responder): the reverse directions.
interface hpdmc_sdram_responder_if;
   logic        cs_n;
   logic        ras_n;
   logic        cas_n;
   logic        we_n;
   logic [1:0]  ba;
   logic [12:0] a;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        dq_oe;
   logic        busy;
   logic        err;

   modport master (
      output cs_n, ras_n, cas_n, we_n, ba, a, wdata, wmask,
      input  rdata, rdata_valid, dq_oe, busy, err
   );

   modport slave (
      input  cs_n, ras_n, cas_n, we_n, ba, a, wdata, wmask,
      output rdata, rdata_valid, dq_oe, busy, err
   );
endinterface

// File: rtl/hpdmc_sdram_responder_mem.sv
// rtl/hpdmc_sdram_responder_mem.sv - 1R1W 32b word array, byte write enables, registered write-first read
// Ports: clk, rst (sync, active-high, clears read register only);
//   we, waddr[AW-1:0], wdata[31:0], wbe[3:0] (1 = byte written);
//   re, raddr[AW-1:0], rdata[31:0] (registered, 0 on cycles without re).
module hpdmc_resp_mem #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wbe,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem_q [0:(1<<AW)-1];
   logic [31:0] merged;

   // Word as it will look after this cycle's write; used to bypass a same-word read.
   always_comb begin
      merged = mem_q[waddr];
      for (int i = 0; i < 4; i++) begin
         if (wbe[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && wbe[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)           rdata <= '0;
      else if (!re)      rdata <= '0;
      else if (we && (waddr == raddr)) rdata <= merged;
      else               rdata <= mem_q[raddr];
   end
endmodule

// File: rtl/hpdmc_sdram_responder.sv
// rtl/hpdmc_sdram_responder.sv - cycle-level DDR SDRAM device emulator on the HPDMC SDR word interface
// Ports: sys_clk, sys_rst (sync, active-high); bus (hpdmc_sdram_responder_if.slave):
//   cs_n/ras_n/cas_n/we_n/ba/a command, wdata/wmask write word, rdata/rdata_valid/dq_oe read word,
//   busy (zeroing sweep), err (sticky protocol error).
// Params: ROW_W row bits kept, COL_W column bits kept (col[0] ignored), INIT_EN zero array at reset.
// Optional: `HPDMC_RESPONDER_CHECK_EN builds the protocol checker driving err; otherwise err is 0.
module hpdmc_sdram_responder
   import hpdmc_resp_pkg::*;
#(
   parameter int ROW_W   = 4,
   parameter int COL_W   = 6,
   parameter int INIT_EN = 0
) (
   input logic                    sys_clk,
   input logic                    sys_rst,
   hpdmc_sdram_responder_if.slave bus
);
   localparam int AW = idx_width(ROW_W, COL_W);
   localparam int CW = COL_W - 1;

   cmd_e              raw_cmd, cmd;
   logic              busy_q;
   logic [AW-1:0]     sweep_q;
   logic [3:0]        open_q;
   logic [ROW_W-1:0]  row_q [4];
   logic              cl3_q;
   logic [1:0]        bl_mask_q;
   burst_state_e      st_q, st_d;
   logic [1:0]        b_bank_q;
   logic [ROW_W-1:0]  b_row_q;
   logic [CW-1:0]     b_col_q;
   logic [1:0]        b_mask_q, b_cnt_q;
   logic              b_cl3_q;
   logic              load, ag_rd, ag_wr;
   logic [CW-1:0]     blk_mask, col_now;
   logic [AW-1:0]     ag_addr;
   logic              d_en_q;
   logic [AW-1:0]     d_addr_q;
   logic              mem_re, mem_we;
   logic [AW-1:0]     mem_raddr, mem_waddr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic [3:0]        mem_wbe;
   logic              vld_q;
   logic              err_q;
   logic              unused_ok;

   assign raw_cmd = bus.cs_n ? CMD_NOP : cmd_e'({bus.ras_n, bus.cas_n, bus.we_n});
   assign cmd     = busy_q ? CMD_NOP : raw_cmd;
   assign load    = (cmd == CMD_READ) || (cmd == CMD_WRITE);

   // ---------------- bank state ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         open_q <= '0;
         for (int i = 0; i < 4; i++) row_q[i] <= '0;
      end else begin
         case (cmd)
            CMD_ACT: begin
               open_q[bus.ba] <= 1'b1;
               row_q[bus.ba]  <= bus.a[ROW_W-1:0];
            end
            CMD_PRE: begin
               if (bus.a[10]) open_q <= '0;
               else           open_q[bus.ba] <= 1'b0;
            end
            CMD_READ, CMD_WRITE: begin
               // auto-precharge: the burst already captured its row below
               if (bus.a[10]) open_q[bus.ba] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- mode register ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cl3_q     <= CL3_RESET;
         bl_mask_q <= BL_MASK_RESET;
      end else if ((cmd == CMD_LMR) && (bus.ba == 2'd0)) begin
         cl3_q     <= cl_decode_is3(bus.a[6:4]);
         bl_mask_q <= bl_decode_mask(bus.a[2:0]);
      end
   end

   // ---------------- burst address generator ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         st_q    <= ST_IDLE;
         b_cnt_q <= '0;
      end else begin
         st_q <= st_d;
         if (load)                b_cnt_q <= '0;
         else if (st_q != ST_IDLE) b_cnt_q <= b_cnt_q + 2'd1;
      end
      // burst parameters are frozen at command time so a later LMR cannot disturb it
      if (load) begin
         b_bank_q <= bus.ba;
         b_row_q  <= row_q[bus.ba];
         b_col_q  <= bus.a[COL_W-1:1];
         b_mask_q <= bl_mask_q;
         b_cl3_q  <= cl3_q;
      end
   end

   always_comb begin
      st_d  = st_q;
      ag_rd = 1'b0;
      ag_wr = 1'b0;
      case (st_q)
         ST_RBURST: begin
            ag_rd = 1'b1;
            if (b_cnt_q == b_mask_q) st_d = ST_IDLE;
         end
         ST_WBURST: begin
            ag_wr = 1'b1;
            if (b_cnt_q == b_mask_q) st_d = ST_IDLE;
         end
         default: ;
      endcase
      // a new command cuts the running burst after this cycle's word
      if (load) st_d = (cmd == CMD_READ) ? ST_RBURST : ST_WBURST;
   end

   // sequential order wrapping inside the aligned block of burst words
   assign blk_mask = CW'(b_mask_q);
   assign col_now  = (b_col_q & ~blk_mask) | ((b_col_q + CW'(b_cnt_q)) & blk_mask);
   assign ag_addr  = {b_bank_q, b_row_q, col_now};

   // ---------------- read delay pipe ----------------
   // CL=3 adds one stage between address generation and the registered array read.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) d_en_q <= 1'b0;
      else         d_en_q <= ag_rd && b_cl3_q;
      d_addr_q <= ag_addr;
   end

   // A CL=3 word in the delay stage wins over a CL=2 word issued the same cycle; that clash
   // only arises when CL is lowered between back-to-back reads.
   assign mem_re    = d_en_q || (ag_rd && !b_cl3_q);
   assign mem_raddr = d_en_q ? d_addr_q : ag_addr;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) vld_q <= 1'b0;
      else         vld_q <= mem_re;
   end

   // ---------------- optional zeroing sweep ----------------
   generate
      if (INIT_EN != 0) begin : g_init
         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               busy_q  <= 1'b1;
               sweep_q <= '0;
            end else if (busy_q) begin
               sweep_q <= sweep_q + AW'(1);
               if (sweep_q == {AW{1'b1}}) busy_q <= 1'b0;
            end
         end
      end else begin : g_no_init
         assign busy_q  = 1'b0;
         assign sweep_q = '0;
      end
   endgenerate

   assign mem_we    = busy_q || ag_wr;
   assign mem_waddr = busy_q ? sweep_q : ag_addr;
   assign mem_wdata = busy_q ? 32'h0 : bus.wdata;
   assign mem_wbe   = busy_q ? 4'hF : ~bus.wmask;

   hpdmc_resp_mem #(.AW(AW)) u_mem (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .wbe   (mem_wbe),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // ---------------- protocol checker ----------------
`ifdef HPDMC_RESPONDER_CHECK_EN
   logic err_set;

   always_comb begin
      err_set = 1'b0;
      if (busy_q) begin
         err_set = (raw_cmd != CMD_NOP);
      end else begin
         case (raw_cmd)
            CMD_READ, CMD_WRITE: err_set = !open_q[bus.ba];
            CMD_ACT:             err_set = open_q[bus.ba];
            CMD_REF:             err_set = |open_q;
            CMD_LMR:             err_set = (|open_q) ||
                                           ((bus.ba == 2'd0) &&
                                            !(cl_legal(bus.a[6:4]) && bl_legal(bus.a[2:0])));
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   assign unused_ok = ^bus.a;

   assign bus.rdata       = mem_rdata;
   assign bus.rdata_valid = vld_q;
   assign bus.dq_oe       = vld_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;
endmodule
